// File: rtl/ifu_fold_pkg.sv
// Shared fold-type encodings and widths for the IFU fold-group path.
package ifu_fold_pkg;
  localparam int FTW    = 6;
  localparam int GSW    = 3;
  localparam int FT_NF  = 0;
  localparam int FT_LV  = 1;
  localparam int FT_OP  = 2;
  localparam int FT_BG2 = 3;
  localparam int FT_BG1 = 4;
  localparam int FT_MEM = 5;
endpackage

// File: rtl/fold_queue_head.sv
// Four-port head view of the fold queue: wrapped read mux with valid masking.
module fold_queue_head #(
  parameter int DEPTH = 8,
  parameter int FTW   = 6,
  parameter int OPW   = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic [DEPTH-1:0][FTW-1:0] ft_mem_i,
  input  logic [DEPTH-1:0][OPW-1:0] op_mem_i,
  input  logic [AW-1:0]             rd_ptr_i,
  input  logic [CW-1:0]             count_i,
  output logic [3:0][FTW-1:0]       ft_o,
  output logic [3:0][OPW-1:0]       op_o,
  output logic [3:0]                vld_o
);
  for (genvar i = 0; i < 4; i++) begin : g_port
    logic [AW-1:0] idx;
    // Pointer sum wraps naturally at AW bits, so a group can straddle DEPTH-1 -> 0.
    assign idx      = rd_ptr_i + AW'(i);
    assign vld_o[i] = count_i > CW'(i);
    assign ft_o[i]  = vld_o[i] ? ft_mem_i[idx] : '0;
    assign op_o[i]  = vld_o[i] ? op_mem_i[idx] : '0;
  end
endmodule

// File: rtl/fold_queue.sv
// Decoded-instruction queue feeding the fold-group decoder; retires the selected group.
module fold_queue #(
  parameter int DEPTH = 8,
  parameter int FTW   = 6,
  parameter int OPW   = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [FTW-1:0] wr_ftype,
  input  logic [OPW-1:0] wr_op,
  input  logic           flush,
  input  logic           hold,
  output logic [FTW-1:0] F0, F1, F2, F3,
  output logic           V0, V1, V2, V3,
  output logic [OPW-1:0] OP0, OP1, OP2, OP3,
  input  logic           fold1, fold2, fold3, fold4,
  output logic           issue_vld,
  output logic [2:0]     issue_cnt,
  output logic           fold_err
);
  import ifu_fold_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][FTW-1:0] ft_mem;
  logic [DEPTH-1:0][OPW-1:0] op_mem;
  logic [AW-1:0]             rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]             count_q;
  logic                      fold_err_q;

  logic [3:0]                fold_v;
  logic                      multi, push, err_set;
  logic [CW-1:0]             req, pop;
  logic [3:0][FTW-1:0]       hd_ft;
  logic [3:0][OPW-1:0]       hd_op;
  logic [3:0]                hd_vld;

  assign wr_ready = (count_q != CW'(DEPTH));
  assign push     = wr_valid & wr_ready;

  always_comb begin
    fold_v = {fold4, fold3, fold2, fold1};
    multi  = $countones(fold_v) > 1;
    req    = '0;
    case (fold_v)
      4'b0001: req = CW'(1);
      4'b0010: req = CW'(2);
      4'b0100: req = CW'(3);
      4'b1000: req = CW'(4);
      default: req = '0;
    endcase
    pop = '0;
    // An over-long group is clamped to what is present; a non-one-hot result retires nothing.
    if (!(hold || flush || multi))
      pop = (req > count_q) ? count_q : req;
    err_set = multi || (!hold && !flush && (req > count_q));
  end

  assign issue_vld = (pop != '0);
  assign issue_cnt = GSW'(pop);
  assign fold_err  = fold_err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      ft_mem[wr_ptr_q] <= wr_ftype;
      op_mem[wr_ptr_q] <= wr_op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fold_err_q <= 1'b0;
    end else begin
      if (err_set) fold_err_q <= 1'b1;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_q + AW'(pop);
        wr_ptr_q <= wr_ptr_q + AW'(push);
        count_q  <= count_q + CW'(push) - pop;
      end
    end
  end

  fold_queue_head #(.DEPTH(DEPTH), .FTW(FTW), .OPW(OPW)) u_head (
    .ft_mem_i (ft_mem),
    .op_mem_i (op_mem),
    .rd_ptr_i (rd_ptr_q),
    .count_i  (count_q),
    .ft_o     (hd_ft),
    .op_o     (hd_op),
    .vld_o    (hd_vld)
  );

  assign {F3, F2, F1, F0}     = hd_ft;
  assign {OP3, OP2, OP1, OP0} = hd_op;
  assign {V3, V2, V1, V0}     = hd_vld;
endmodule

// File: tb/tb_fold_queue.sv
// Randomized + directed check of fold_queue against a queue-based reference model.
module tb_fold_queue;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [5:0] wr_ftype = '0;
  logic [7:0] wr_op = '0;
  logic       fold1 = 1'b0, fold2 = 1'b0, fold3 = 1'b0, fold4 = 1'b0;
  logic       wr_ready, issue_vld, fold_err;
  logic [2:0] issue_cnt;
  logic [5:0] F0, F1, F2, F3;
  logic [7:0] OP0, OP1, OP2, OP3;
  logic       V0, V1, V2, V3;

  fold_queue #(.DEPTH(DEPTH), .FTW(6), .OPW(8)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ftype(wr_ftype), .wr_op(wr_op), .flush(flush), .hold(hold),
    .F0(F0), .F1(F1), .F2(F2), .F3(F3), .V0(V0), .V1(V1), .V2(V2), .V3(V3),
    .OP0(OP0), .OP1(OP1), .OP2(OP2), .OP3(OP3),
    .fold1(fold1), .fold2(fold2), .fold3(fold3), .fold4(fold4),
    .issue_vld(issue_vld), .issue_cnt(issue_cnt), .fold_err(fold_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] ft; logic [7:0] op; } ent_t;
  ent_t q[$];
  bit   m_err;
  int   n_chk = 0, n_fail = 0;

  logic [3:0][5:0] fv;
  logic [3:0][7:0] ov;
  logic [3:0]      vv;
  assign fv = {F3, F2, F1, F0};
  assign ov = {OP3, OP2, OP1, OP0};
  assign vv = {V3, V2, V1, V0};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Group size the decoder's result should retire, from the rules alone.
  function automatic int model_pop();
    int n, req;
    n   = int'(fold1) + int'(fold2) + int'(fold3) + int'(fold4);
    req = fold1 ? 1 : fold2 ? 2 : fold3 ? 3 : fold4 ? 4 : 0;
    if (flush || hold || n > 1) return 0;
    return (req < q.size()) ? req : q.size();
  endfunction

  task automatic compare_all();
    int p;
    p = model_pop();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("V%0d", i), int'(vv[i]), int'(q.size() > i));
      chk($sformatf("F%0d", i), int'(fv[i]), q.size() > i ? int'(q[i].ft) : 0);
      chk($sformatf("OP%0d", i), int'(ov[i]), q.size() > i ? int'(q[i].op) : 0);
    end
    chk("wr_ready", int'(wr_ready), int'(q.size() < DEPTH));
    chk("issue_vld", int'(issue_vld), int'(p != 0));
    chk("issue_cnt", int'(issue_cnt), p);
    chk("fold_err", int'(fold_err), int'(m_err));
  endtask

  task automatic drive(input bit wv, input logic [5:0] ft, input logic [7:0] op,
                       input bit fl, input bit hd, input logic [3:0] fb);
    @(negedge clk);
    wr_valid = wv; wr_ftype = ft; wr_op = op; flush = fl; hold = hd;
    {fold4, fold3, fold2, fold1} = fb;
    #1 compare_all();
  endtask

  task automatic step();
    int n, req, p;
    bit psh;
    @(posedge clk);
    n   = int'(fold1) + int'(fold2) + int'(fold3) + int'(fold4);
    req = fold1 ? 1 : fold2 ? 2 : fold3 ? 3 : fold4 ? 4 : 0;
    p   = model_pop();
    psh = wr_valid && (q.size() < DEPTH);
    if (n > 1 || (!hold && !flush && req > q.size())) m_err = 1'b1;
    if (flush) q.delete();
    else begin
      repeat (p) void'(q.pop_front());
      if (psh) q.push_back('{ft: wr_ftype, op: wr_op});
    end
  endtask

  task automatic cyc(input bit wv, input logic [5:0] ft, input bit fl, input bit hd,
                     input logic [3:0] fb);
    drive(wv, ft, 8'($urandom), fl, hd, fb);
    step();
  endtask

  task automatic idle_view();
    drive(1'b0, 6'h0, 8'h0, 1'b0, 1'b0, 4'b0000);
  endtask

  logic [5:0] t1_ft[4] = '{6'h02, 6'h02, 6'h04, 6'h20};
  logic [5:0] t3_ft[4] = '{6'h01, 6'h02, 6'h04, 6'h08};

  initial begin
    m_err = 1'b0;
    #12;
    chk("rst_V", int'(vv), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_issue", int'({issue_vld, issue_cnt}), 0);
    chk("rst_fold_err", int'(fold_err), 0);
    @(negedge clk) reset = 1'b0;

    // 1: four pushes, then a fold4 retires them all
    for (int i = 0; i < 4; i++) cyc(1'b1, t1_ft[i], 1'b0, 1'b0, 4'b0000);
    idle_view();
    chk("t1_V", int'(vv), 4'hF);
    chk("t1_F", int'(fv), int'({6'h20, 6'h04, 6'h02, 6'h02}));
    drive(1'b0, 6'h0, 8'h0, 1'b0, 1'b0, 4'b1000);
    chk("t1_issue_cnt", int'(issue_cnt), 4);
    step();
    idle_view();
    chk("t1_V_after", int'(vv), 0);

    // 2: fill, then a push offered alongside fold2 while full is refused
    repeat (DEPTH) cyc(1'b1, 6'($urandom), 1'b0, 1'b0, 4'b0000);
    idle_view();
    chk("t2_full_ready", int'(wr_ready), 0);
    drive(1'b1, 6'h3F, 8'hEE, 1'b0, 1'b0, 4'b0010);
    chk("t2_issue_cnt", int'(issue_cnt), 2);
    step();
    idle_view();
    chk("t2_ready_after", int'(wr_ready), 1);
    chk("t2_model_count", q.size(), 6);

    // 3: park the pointers at 6 and straddle the wrap with fold3
    cyc(1'b0, 6'h0, 1'b1, 1'b0, 4'b0000);
    repeat (6) cyc(1'b1, 6'h10, 1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 6'h0, 1'b0, 1'b0, 4'b1000);
    cyc(1'b0, 6'h0, 1'b0, 1'b0, 4'b0010);
    for (int i = 0; i < 4; i++) cyc(1'b1, t3_ft[i], 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 6'h0, 8'h0, 1'b0, 1'b0, 4'b0100);
    chk("t3_F012", int'({F2, F1, F0}), int'({6'h04, 6'h02, 6'h01}));
    step();
    idle_view();
    chk("t3_V_after", int'(vv), 4'b0001);
    chk("t3_F0_after", int'(F0), 6'h08);

    // 4: hold blocks retirement; flush drops a same-cycle push
    cyc(1'b1, 6'h02, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 6'h0, 8'h0, 1'b0, 1'b1, 4'b0010);
    chk("t4_hold_issue", int'(issue_vld), 0);
    step();
    idle_view();
    chk("t4_V_held", int'(vv), 4'b0011);
    cyc(1'b1, 6'h20, 1'b1, 1'b0, 4'b0000);
    idle_view();
    chk("t4_V_flushed", int'(vv), 0);

    // 5: over-long group clamps and flags; multi-hot retires nothing
    cyc(1'b1, 6'h04, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 6'h0, 8'h0, 1'b0, 1'b0, 4'b0100);
    chk("t5_clamp_cnt", int'(issue_cnt), 1);
    step();
    idle_view();
    chk("t5_err", int'(fold_err), 1);
    cyc(1'b1, 6'h01, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 6'h0, 8'h0, 1'b0, 1'b0, 4'b0011);
    chk("t5_multi_issue", int'(issue_vld), 0);
    step();
    idle_view();
    chk("t5_err_sticky", int'(fold_err), 1);

    // 6: asynchronous reset mid-cycle with five entries queued
    repeat (4) cyc(1'b1, 6'($urandom), 1'b0, 1'b0, 4'b0000);
    idle_view();
    chk("t6_pre_V", int'(vv), 4'hF);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_V", int'(vv), 0);
    chk("t6_async_ready", int'(wr_ready), 1);
    chk("t6_async_issue", int'(issue_vld), 0);
    q.delete();
    m_err = 1'b0;
    @(negedge clk) reset = 1'b0;

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [3:0] fb;
      r  = $urandom_range(0, 19);
      fb = (r < 6)  ? 4'b0000 :
           (r < 19) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      cyc($urandom_range(0, 9) < 7, 6'($urandom), $urandom_range(0, 39) == 0,
          $urandom_range(0, 9) == 0, fb);
    end
    idle_view();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
